uart_byte_rx: RTL and testbench

//   8N1 UART byte receiver, the receive-side counterpart of uart_byte_tx. Synchronises the serial

---
 rtl/uart_byte_rx_pkg.sv | 44 ++++
 rtl/uart_byte_rx_baud_tick.sv | 29 ++
 rtl/uart_byte_rx.sv | 122 ++++++++++++
 tb/tb_uart_byte_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver: baud codes, FSM state encoding,
// sample positions and the per-code divisor helper.
package uart_byte_rx_pkg;

    localparam int unsigned OVERSAMP_RATE = 16;
    localparam int unsigned DIV_W         = 9;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Majority-vote window around mid-bit; the last sample is also the decision point.
    localparam logic [3:0] SAMP_FIRST = 4'd7;
    localparam logic [3:0] SAMP_MID   = 4'd8;
    localparam logic [3:0] SAMP_LAST  = 4'd9;

    // Each branch divides constants only, so no divider is built in hardware.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code,
                                                  input int unsigned clk_freq);
        case (code)
            BAUD_19200:  return DIV_W'(clk_freq / (19200  * OVERSAMP_RATE) - 1);
            BAUD_38400:  return DIV_W'(clk_freq / (38400  * OVERSAMP_RATE) - 1);
            BAUD_57600:  return DIV_W'(clk_freq / (57600  * OVERSAMP_RATE) - 1);
            BAUD_115200: return DIV_W'(clk_freq / (115200 * OVERSAMP_RATE) - 1);
            default:     return DIV_W'(clk_freq / (9600   * OVERSAMP_RATE) - 1);
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_rx_baud_tick.sv
// Oversampling tick generator: counts 0..i_div while enabled and pulses o_tick on the
// terminal value; held at zero while disabled so every frame starts phase-aligned.
module uart_byte_rx_baud_tick
    import uart_byte_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] cnt_q;
    logic             at_end;

    assign at_end = (cnt_q == i_div);
    assign o_tick = i_en && at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!i_en || at_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchronised line, 16x oversampling, majority vote on samples
// 7/8/9 of each bit, LSB-first reassembly with one-cycle Done / FrameErr strobes.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned OVERSAMP = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_RXD_Rx,
    input  logic [2:0] i_RXD_Baud,
    output logic [7:0] o_RXD_Dout,
    output logic       o_RXD_Done,
    output logic       o_RXD_FrameErr,
    output logic       o_RXD_State
);

    localparam logic [3:0] S_LAST = 4'(OVERSAMP - 1);

    logic             sync1_q, rx_s_q, rx_d_q;
    rx_state_e        state_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       s_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [1:0]       samp_q;
    logic [7:0]       shreg_q;
    logic [7:0]       dout_q;
    logic             done_q, ferr_q;
    logic             tick, tick_en, bit_v, start_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= i_RXD_Rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    assign start_edge = rx_d_q && !rx_s_q;
    assign tick_en    = (state_q != ST_IDLE);
    assign bit_v      = majority3(samp_q[0], samp_q[1], rx_s_q);

    uart_byte_rx_baud_tick u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (tick_en),
        .i_div  (div_q),
        .o_tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            s_cnt_q   <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    s_cnt_q   <= '0;
                    bit_cnt_q <= '0;
                    if (start_edge) begin
                        state_q <= ST_START;
                        div_q   <= baud_div(i_RXD_Baud, CLK_FREQ);
                    end
                end
                default: begin
                    if (tick) begin
                        s_cnt_q <= (s_cnt_q == S_LAST) ? 4'd0 : s_cnt_q + 4'd1;
                        if (s_cnt_q == SAMP_FIRST) samp_q[0] <= rx_s_q;
                        if (s_cnt_q == SAMP_MID)   samp_q[1] <= rx_s_q;
                        if (s_cnt_q == SAMP_LAST) begin
                            case (state_q)
                                ST_START: begin
                                    state_q   <= bit_v ? ST_IDLE : ST_DATA;
                                    bit_cnt_q <= '0;
                                end
                                ST_DATA: begin
                                    shreg_q <= {bit_v, shreg_q[7:1]};
                                    if (bit_cnt_q == 3'd7) begin
                                        state_q <= ST_STOP;
                                    end else begin
                                        bit_cnt_q <= bit_cnt_q + 3'd1;
                                    end
                                end
                                ST_STOP: begin
                                    // Leave mid-stop-bit so an immediately following start edge is seen.
                                    state_q <= ST_IDLE;
                                    if (bit_v) begin
                                        dout_q <= shreg_q;
                                        done_q <= 1'b1;
                                    end else begin
                                        ferr_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign o_RXD_Dout     = dout_q;
    assign o_RXD_Done     = done_q;
    assign o_RXD_FrameErr = ferr_q;
    assign o_RXD_State    = tick_en;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: vector table, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_uart_byte_rx;

    localparam int CLK_HZ = 25_000_000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [2:0] baud  = 3'd4;
    logic [7:0] dout;
    logic       done, ferr, state;

    uart_byte_rx #(.CLK_FREQ(CLK_HZ), .OVERSAMP(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_RXD_Rx       (rx),
        .i_RXD_Baud     (baud),
        .o_RXD_Dout     (dout),
        .o_RXD_Done     (done),
        .o_RXD_FrameErr (ferr),
        .o_RXD_State    (state)
    );

    always #20 clk = ~clk;

    int         checks = 0, errors = 0;
    int         cyc = 0;
    int         done_n = 0, ferr_n = 0, evt_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] model_dout = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && (done || ferr)) begin
            chk("done/ferr exclusive", {31'b0, done & ferr}, 32'd0);
            evt_cyc = cyc;
            if (done) begin
                done_n++;
                last_byte = dout;
            end
            if (ferr) ferr_n++;
        end
    end

    // Oversampling ticks per sample period, from the baud code.
    function automatic int ticks(input logic [2:0] code);
        int rate;
        case (code)
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            default: rate = 9600;
        endcase
        return CLK_HZ / (rate * 16);
    endfunction

    // Called on a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int bit_clks,
                              output int t0);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (bit_clks) @(negedge clk);
        end
    endtask

    // Event lands 3 sync/edge cycles plus 154 ticks (stop bit, sample 9) after the falling edge.
    task automatic check_frame(input string name, input logic [7:0] data, input logic stop,
                               input int t0, input int n, input int d0, input int f0);
        if (stop) model_dout = data;
        chk({name, " done count"}, done_n - d0, stop ? 1 : 0);
        chk({name, " ferr count"}, ferr_n - f0, stop ? 0 : 1);
        if (stop) chk({name, " byte"}, last_byte, data);
        chk({name, " latency"}, evt_cyc - t0, 3 + 154 * n);
        chk({name, " dout"}, dout, model_dout);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [2:0] code;
        int         adj;
        logic       exp_done;
        logic       exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t       tbl[6];
    int         t0, d0, f0, n, dummy, adj;
    logic [7:0] dat;
    logic       stp;

    initial begin
        #(64'd40 * 64'd200_000);
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h7A, 1'b1, 3'd4,  1, 1'b1, 1'b0, 8'h7A};
        tbl[1] = '{8'h3C, 1'b0, 3'd4,  0, 1'b0, 1'b1, 8'h7A};
        tbl[2] = '{8'h00, 1'b1, 3'd4,  0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 3'd3,  0, 1'b1, 1'b0, 8'hFF};
        tbl[4] = '{8'h81, 1'b0, 3'd2,  0, 1'b0, 1'b1, 8'hFF};
        tbl[5] = '{8'hC3, 1'b1, 3'd4, -1, 1'b1, 1'b0, 8'hC3};

        repeat (5) @(negedge clk);
        chk("reset dout", dout, 8'h00);
        chk("reset done", done, 1'b0);
        chk("reset ferr", ferr, 1'b0);
        chk("reset state", state, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            baud = tbl[i].code;
            repeat (20) @(negedge clk);
            d0 = done_n; f0 = ferr_n;
            n  = ticks(tbl[i].code);
            send_frame(tbl[i].data, tbl[i].stop, n * 16 + tbl[i].adj, t0);
            rx = 1'b1;
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d done", i), done_n - d0, tbl[i].exp_done);
            chk($sformatf("vec%0d ferr", i), ferr_n - f0, tbl[i].exp_ferr);
            chk($sformatf("vec%0d dout", i), dout, tbl[i].exp_dout);
            chk($sformatf("vec%0d latency", i), evt_cyc - t0, 3 + 154 * n);
            if (tbl[i].exp_done) chk($sformatf("vec%0d byte", i), last_byte, tbl[i].data);
            model_dout = tbl[i].exp_dout;
        end

        // Back-to-back frames with no idle gap.
        baud = 3'd4; n = ticks(3'd4);
        repeat (20) @(negedge clk);
        d0 = done_n; f0 = ferr_n;
        send_frame(8'h55, 1'b1, n * 16, t0);
        check_frame("b2b 55", 8'h55, 1'b1, t0, n, d0, f0);
        d0 = done_n; f0 = ferr_n;
        send_frame(8'hAA, 1'b1, n * 16, t0);
        check_frame("b2b AA", 8'hAA, 1'b1, t0, n, d0, f0);
        repeat (20) @(negedge clk);

        // Glitch shorter than the start-bit check: false start, no pulses.
        d0 = done_n; f0 = ferr_n;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch state busy", state, 1'b1);
        repeat (5 * n - 5) @(negedge clk);
        rx = 1'b1;
        repeat (10 * n) @(negedge clk);
        chk("glitch state idle", state, 1'b0);
        chk("glitch done", done_n - d0, 0);
        chk("glitch ferr", ferr_n - f0, 0);
        repeat (20) @(negedge clk);

        // Break: line stays low after a low stop bit; no re-trigger.
        d0 = done_n; f0 = ferr_n;
        send_frame(8'h00, 1'b0, n * 16, t0);
        repeat (12 * n * 16) @(negedge clk);
        chk("break ferr", ferr_n - f0, 1);
        chk("break done", done_n - d0, 0);
        chk("break latency", evt_cyc - t0, 3 + 154 * n);
        chk("break state", state, 1'b0);
        chk("break dout", dout, model_dout);
        rx = 1'b1;
        repeat (40) @(negedge clk);

        // Reserved code decodes as 9600; a mid-frame code change is ignored.
        baud = 3'd6; n = ticks(3'd6);
        repeat (20) @(negedge clk);
        d0 = done_n; f0 = ferr_n;
        fork
            send_frame(8'hA5, 1'b1, n * 16, t0);
            begin
                repeat (5 * n * 16) @(negedge clk);
                baud = 3'd4;
            end
        join
        check_frame("9600 A5", 8'hA5, 1'b1, t0, n, d0, f0);
        repeat (20) @(negedge clk);

        // Reset during data bit 4 of 0xFF.
        n = ticks(3'd4);
        d0 = done_n; f0 = ferr_n;
        fork
            send_frame(8'hFF, 1'b1, n * 16, dummy);
            begin
                repeat (5 * n * 16 + 100) @(negedge clk);
                chk("pre-reset state", state, 1'b1);
                rst_n = 1'b0;
                #1;
                chk("midreset dout", dout, 8'h00);
                chk("midreset done", done, 1'b0);
                chk("midreset ferr", ferr, 1'b0);
                chk("midreset state", state, 1'b0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        model_dout = 8'h00;
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("post-reset done", done_n - d0, 0);
        chk("post-reset ferr", ferr_n - f0, 0);
        chk("post-reset dout", dout, 8'h00);
        d0 = done_n; f0 = ferr_n;
        send_frame(8'h12, 1'b1, n * 16, t0);
        check_frame("after reset 12", 8'h12, 1'b1, t0, n, d0, f0);
        repeat (20) @(negedge clk);

        // Random frames with small sender clock error.
        for (int k = 0; k < 5; k++) begin
            dat = 8'($urandom);
            stp = ($urandom_range(0, 3) != 0);
            adj = int'($urandom_range(0, 2)) - 1;
            d0 = done_n; f0 = ferr_n;
            send_frame(dat, stp, n * 16 + adj, t0);
            rx = 1'b1;
            repeat (20) @(negedge clk);
            check_frame($sformatf("rand%0d", k), dat, stp, t0, n, d0, f0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
